serializador: RTL and testbench

Parallel-to-serial stage that feeds the 1-bit `ent` input of the downstream sequence-analysis FSM. It accepts a W-bit word through a valid/ready handshake and shifts it out one bit per `clk`, with a per-bit valid strobe and an end-of-word pulse. An optional idle gap is inserted between words. All logic sits in the same `clk` domain as the analysis FSM.

---
 rtl/serializador.sv | 143 ++++++++++++++
 tb/tb_serializador.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serializador.sv
// serializador: parallel-to-serial stage feeding the 1-bit input of the
// sequence-analysis FSM. Accepts a W-bit word through a valid/ready handshake,
// then shifts it out one bit per clock with a per-bit valid strobe and an
// end-of-word pulse, optionally followed by GAP idle cycles.
module serializador #(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] dado,
  input  logic         carga,
  output logic         pronto,
  output logic         ent,
  output logic         bit_valido,
  output logic         fim,
  output logic         ocupado
);

  localparam int          CW    = $clog2(W) + 1;
  localparam logic [CW-1:0] W_C   = CW'(W);
  localparam logic [3:0]    GAP_C = 4'(GAP);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    PAUSA   = 2'd2
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [W-1:0]  desloc_q, desloc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic          ent_q, ent_d;
  logic          bv_q, bv_d;
  logic          fim_q, fim_d;

  // Bit that leaves the word next, depending on shift direction.
  function automatic logic cabeca(input logic [W-1:0] v);
    if (MSB_FIRST != 0) begin
      return v[W-1];
    end else begin
      return v[0];
    end
  endfunction

  // Word after discarding its head bit.
  function automatic logic [W-1:0] desloca(input logic [W-1:0] v);
    if (MSB_FIRST != 0) begin
      return {v[W-2:0], 1'b0};
    end else begin
      return {1'b0, v[W-1:1]};
    end
  endfunction

  // Ready depends only on state and reset so upstream never sees a loop through carga.
  assign pronto     = (estado_q == OCIOSO) & ~rst;
  assign ent        = ent_q;
  assign bit_valido = bv_q;
  assign fim        = fim_q;
  assign ocupado    = (estado_q != OCIOSO);

  // Next-state and next-output logic; outputs are computed one edge early so they come out registered.
  always_comb begin
    estado_d = estado_q;
    desloc_d = desloc_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    ent_d    = 1'b0;
    bv_d     = 1'b0;
    fim_d    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (carga) begin
          // Handshake: the head bit is presented in the very next cycle.
          estado_d = DESLOCA;
          desloc_d = dado;
          cnt_d    = W_C;
          ent_d    = cabeca(dado);
          bv_d     = 1'b1;
        end else begin
          estado_d = OCIOSO;
        end
      end
      DESLOCA: begin
        // cnt_q counts bits still on the wire, including the one shown now.
        if (cnt_q > CW'(1)) begin
          desloc_d = desloca(desloc_q);
          cnt_d    = cnt_q - CW'(1);
          ent_d    = cabeca(desloca(desloc_q));
          bv_d     = 1'b1;
          fim_d    = (cnt_q == CW'(2));
        end else begin
          desloc_d = '0;
          cnt_d    = '0;
          if (GAP > 0) begin
            estado_d = PAUSA;
            gap_d    = GAP_C;
          end else begin
            estado_d = OCIOSO;
          end
        end
      end
      PAUSA: begin
        if (gap_q <= 4'd1) begin
          estado_d = OCIOSO;
          gap_d    = 4'd0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        estado_d = OCIOSO;
        desloc_d = '0;
        cnt_d    = '0;
        gap_d    = 4'd0;
      end
    endcase
  end

  // State and output registers; reset wins over every transition and drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      desloc_q <= '0;
      cnt_q    <= '0;
      gap_q    <= 4'd0;
      ent_q    <= 1'b0;
      bv_q     <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      desloc_q <= desloc_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      ent_q    <= ent_d;
      bv_q     <= bv_d;
      fim_q    <= fim_d;
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: three instances cover MSB-first/no gap,
// LSB-first/no gap and MSB-first with a 3-cycle gap.
module tb_serializador;

  logic       clk;
  logic       rst;
  logic [7:0] dado0, dado1, dado2;
  logic       carga0, carga1, carga2;
  logic       pronto0, ent0, bv0, fim0, ocup0;
  logic       pronto1, ent1, bv1, fim1, ocup1;
  logic       pronto2, ent2, bv2, fim2, ocup2;

  int checks   = 0;
  int failures = 0;

  serializador #(.W(8), .MSB_FIRST(1), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .dado(dado0), .carga(carga0), .pronto(pronto0),
    .ent(ent0), .bit_valido(bv0), .fim(fim0), .ocupado(ocup0));

  serializador #(.W(8), .MSB_FIRST(0), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .dado(dado1), .carga(carga1), .pronto(pronto1),
    .ent(ent1), .bit_valido(bv1), .fim(fim1), .ocupado(ocup1));

  serializador #(.W(8), .MSB_FIRST(1), .GAP(3)) u2 (
    .clk(clk), .rst(rst), .dado(dado2), .carga(carga2), .pronto(pronto2),
    .ent(ent2), .bit_valido(bv2), .fim(fim2), .ocupado(ocup2));

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus sequence.
  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    carga0 = 1'b0; carga1 = 1'b0; carga2 = 1'b0;
    dado0 = 8'h00; dado1 = 8'h00; dado2 = 8'h00;
    tick();
    tick();
    chk("rst_pronto", 32'(pronto0), 32'd0);
    chk("rst_ent", 32'(ent0), 32'd0);
    chk("rst_ocupado", 32'(ocup0), 32'd0);

    rst = 1'b0;
    #1;
    chk("idle_pronto", 32'(pronto0), 32'd1);
    chk("idle_ent", 32'(ent0), 32'd0);
    chk("idle_bv", 32'(bv0), 32'd0);
    chk("idle_fim", 32'(fim0), 32'd0);
    chk("idle_ocupado", 32'(ocup0), 32'd0);

    // MSB first, 8'hB4 -> 1,0,1,1,0,1,0,0
    pat = 8'hB4;
    dado0 = 8'hB4; carga0 = 1'b1;
    tick();
    carga0 = 1'b0; dado0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("msb_ent%0d", i), 32'(ent0), 32'(pat[7-i]));
      chk($sformatf("msb_bv%0d", i), 32'(bv0), 32'd1);
      chk($sformatf("msb_fim%0d", i), 32'(fim0), 32'(i == 7));
      chk($sformatf("msb_pronto%0d", i), 32'(pronto0), 32'd0);
      tick();
    end
    chk("msb_after_pronto", 32'(pronto0), 32'd1);
    chk("msb_after_bv", 32'(bv0), 32'd0);
    chk("msb_after_fim", 32'(fim0), 32'd0);
    chk("msb_after_ocupado", 32'(ocup0), 32'd0);

    // LSB first, 8'hB4 -> 0,0,1,0,1,1,0,1
    dado1 = 8'hB4; carga1 = 1'b1;
    tick();
    carga1 = 1'b0; dado1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_ent%0d", i), 32'(ent1), 32'(pat[i]));
      chk($sformatf("lsb_fim%0d", i), 32'(fim1), 32'(i == 7));
      tick();
    end
    chk("lsb_after_pronto", 32'(pronto1), 32'd1);

    // GAP=3, carga held: 8'hFF then 8'h01 (dado changes mid-word)
    dado2 = 8'hFF; carga2 = 1'b1;
    tick();
    dado2 = 8'h01;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("gap_w1_ent%0d", i), 32'(ent2), 32'd1);
      chk($sformatf("gap_w1_bv%0d", i), 32'(bv2), 32'd1);
      chk($sformatf("gap_w1_fim%0d", i), 32'(fim2), 32'(i == 7));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("gap_pause_bv%0d", i), 32'(bv2), 32'd0);
      chk($sformatf("gap_pause_ocupado%0d", i), 32'(ocup2), 32'd1);
      chk($sformatf("gap_pause_pronto%0d", i), 32'(pronto2), 32'd0);
      tick();
    end
    chk("gap_hs_pronto", 32'(pronto2), 32'd1);
    chk("gap_hs_ocupado", 32'(ocup2), 32'd0);
    chk("gap_hs_bv", 32'(bv2), 32'd0);
    tick();
    carga2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("gap_w2_ent%0d", i), 32'(ent2), 32'(i == 7));
      chk($sformatf("gap_w2_bv%0d", i), 32'(bv2), 32'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    chk("gap_drain_pronto", 32'(pronto2), 32'd1);

    // Reset after the 4th bit of 8'hAA
    pat = 8'hAA;
    dado0 = 8'hAA; carga0 = 1'b1;
    tick();
    carga0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rmid_ent%0d", i), 32'(ent0), 32'(pat[7-i]));
      if (i < 3) tick();
    end
    rst = 1'b1;
    #1;
    chk("rmid_pronto_in_rst", 32'(pronto0), 32'd0);
    tick();
    chk("rmid_ent", 32'(ent0), 32'd0);
    chk("rmid_bv", 32'(bv0), 32'd0);
    chk("rmid_fim", 32'(fim0), 32'd0);
    chk("rmid_ocupado", 32'(ocup0), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rmid_nofim%0d", i), 32'(fim0), 32'd0);
      chk($sformatf("rmid_nobv%0d", i), 32'(bv0), 32'd0);
    end

    // Clean word after reset: 8'h0F -> 0,0,0,0,1,1,1,1
    pat = 8'h0F;
    dado0 = 8'h0F; carga0 = 1'b1;
    tick();
    carga0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post_ent%0d", i), 32'(ent0), 32'(pat[7-i]));
      chk($sformatf("post_fim%0d", i), 32'(fim0), 32'(i == 7));
      tick();
    end

    // rst and carga together: nothing accepted
    rst = 1'b1; dado0 = 8'hFF; carga0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rc_ocupado%0d", i), 32'(ocup0), 32'd0);
      chk($sformatf("rc_bv%0d", i), 32'(bv0), 32'd0);
      chk($sformatf("rc_pronto%0d", i), 32'(pronto0), 32'd0);
    end
    carga0 = 1'b0;
    rst = 1'b0;
    tick();
    chk("rc_after_ocupado", 32'(ocup0), 32'd0);
    chk("rc_after_bv", 32'(bv0), 32'd0);
    chk("rc_after_pronto", 32'(pronto0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
